alu_mul_sequencer: RTL and testbench

//  Multi-cycle shift-add multiplier controller (RV32M MUL, low WIDTH bits).

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_mul_sequencer_if.sv | 30 +++
 rtl/alu_mul_sequencer.sv | 101 ++++++++++
 tb/tb_alu_mul_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcodes and multiply-sequencer state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } mulseq_state_t;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Operand/result handshake plus shared-ALU req/gnt port of the multiply sequencer.
// master = sequencer side, slave = core side (operand source, result sink, ALU owner).
interface alu_mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] Product;
    logic             Busy;
    logic             AluReq;
    logic             AluGnt;
    logic [WIDTH-1:0] AluA;
    logic [WIDTH-1:0] AluB;
    logic [2:0]       AluControl;
    logic [WIDTH-1:0] AluResult;

    modport master (
        input  InValid, OpA, OpB, OutReady, AluGnt, AluResult,
        output InReady, OutValid, Product, Busy, AluReq, AluA, AluB, AluControl
    );

    modport slave (
        output InValid, OpA, OpB, OutReady, AluGnt, AluResult,
        input  InReady, OutValid, Product, Busy, AluReq, AluA, AluB, AluControl
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier (low WIDTH bits) that borrows the core's shared ALU for each add.
// Latency: N+1+S cycles from accept (N = iterations, S = cycles waiting for AluGnt).
// Backpressure: one op at a time; InReady only in idle; Product/OutValid held until OutReady.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 Flush,
    alu_mul_sequencer_if.master  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mulseq_state_t    state, state_nxt;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [CNT_W-1:0] cnt;
    logic             take, adv, last_iter, alu_req;

    // Flush is applied last so it overrides every transition and blocks any register update.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        adv       = 1'b0;
        last_iter = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.InValid) begin
                    take      = 1'b1;
                    state_nxt = (EARLY_EXIT && (bus.OpB == '0)) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                adv       = !mplier[0] || bus.AluGnt;
                last_iter = (cnt == CNT_W'(WIDTH - 1)) ||
                            (EARLY_EXIT && ((mplier >> 1) == '0));
                if (adv && last_iter) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.OutReady) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (Flush) begin
            state_nxt = S_IDLE;
            take      = 1'b0;
            adv       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A stalled iteration (req without gnt) leaves every register untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (take) begin
            acc    <= '0;
            mcand  <= bus.OpA;
            mplier <= bus.OpB;
            cnt    <= '0;
        end else if (adv) begin
            if (mplier[0]) begin
                acc <= bus.AluResult;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    assign alu_req = (state == S_RUN) && mplier[0];

    // Shared ALU bus is parked at zero whenever we are not requesting it.
    assign bus.AluReq     = alu_req;
    assign bus.AluA       = alu_req ? acc   : '0;
    assign bus.AluB       = alu_req ? mcand : '0;
    assign bus.AluControl = alu_req ? ALU_ADD : 3'b000;

    assign bus.InReady  = (state == S_IDLE);
    assign bus.Busy     = (state != S_IDLE);
    assign bus.OutValid = (state == S_DONE);
    assign bus.Product  = acc;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a scoreboard of expected products and a behavioural ALU.
`timescale 1ns/1ps
module tb_alu_mul_sequencer;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset_n;
    logic flush, flush0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [WIDTH-1:0] sb[$];

    int   lat0, nreq0, ov_cnt;
    bit   done0;

    alu_mul_sequencer_if #(.WIDTH(WIDTH)) bus ();
    alu_mul_sequencer_if #(.WIDTH(WIDTH)) bus0 ();

    alu_mul_sequencer #(.WIDTH(WIDTH), .EARLY_EXIT(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n), .Flush(flush), .bus(bus)
    );
    alu_mul_sequencer #(.WIDTH(WIDTH), .EARLY_EXIT(1'b0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .Flush(flush0), .bus(bus0)
    );

    assign bus.AluResult  = bus.AluA + bus.AluB;
    assign bus0.AluResult = bus0.AluA + bus0.AluB;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit push);
        logic [WIDTH-1:0] p;
        @(negedge clk);
        check("in_ready_before_accept", bus.InReady, 1);
        bus.InValid = 1'b1;
        bus.OpA     = a;
        bus.OpB     = b;
        p = a * b;
        if (push) sb.push_back(p);
        @(posedge clk);
    endtask

    task automatic handshake(input string tag);
        bus.OutReady = 1'b1;
        @(negedge clk);
        bus.OutReady = 1'b0;
        check({tag, "_post_outvalid"}, bus.OutValid, 0);
        check({tag, "_post_inready"}, bus.InReady, 1);
    endtask

    // Runs from the accept edge until OutValid, granting the ALU except for 'stalls' requested cycles.
    task automatic wait_result(input int stalls, input int exp_lat, input int exp_nreq,
                               input int exp_first, input bit do_hs, input string tag);
        int cyc = 0, nreq = 0, first_req = 0, bus_bad = 0, left = stalls;
        bit stalled = 1'b0, done = 1'b0;
        logic [WIDTH-1:0] held = '0;
        logic [WIDTH-1:0] exp_p;
        for (int c = 1; c <= 200 && !done; c++) begin
            @(negedge clk);
            bus.InValid = 1'b0;
            if (stalled) check({tag, "_acc_held"}, bus.Product, held);
            stalled = 1'b0;
            if (bus.OutValid) begin
                cyc  = c;
                done = 1'b1;
            end else begin
                if (bus.AluReq) begin
                    nreq++;
                    if (first_req == 0) first_req = c;
                    if (bus.AluControl !== ALU_ADD) bus_bad++;
                end else if (bus.AluA !== '0 || bus.AluB !== '0 || bus.AluControl !== 3'b000) begin
                    bus_bad++;
                end
                if (bus.AluReq && left > 0) begin
                    bus.AluGnt = 1'b0;
                    left--;
                    stalled = 1'b1;
                    held    = bus.Product;
                end else begin
                    bus.AluGnt = 1'b1;
                end
            end
        end
        bus.AluGnt = 1'b1;
        check({tag, "_no_timeout"}, done, 1);
        if (done) begin
            exp_p = sb.pop_front();
            check({tag, "_latency"}, cyc, exp_lat);
            check({tag, "_product"}, bus.Product, exp_p);
            check({tag, "_req_cycles"}, nreq, exp_nreq);
            check({tag, "_first_req"}, first_req, exp_first);
            check({tag, "_alu_bus"}, bus_bad, 0);
            if (do_hs) handshake(tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        flush = 1'b0; flush0 = 1'b0;
        bus.InValid = 1'b0;  bus.OpA = '0;  bus.OpB = '0;  bus.OutReady = 1'b0;  bus.AluGnt = 1'b1;
        bus0.InValid = 1'b0; bus0.OpA = '0; bus0.OpB = '0; bus0.OutReady = 1'b0; bus0.AluGnt = 1'b1;
        #12;
        check("rst_inready", bus.InReady, 1);
        check("rst_busy", bus.Busy, 0);
        check("rst_outvalid", bus.OutValid, 0);
        check("rst_product", bus.Product, 0);
        check("rst_alureq", bus.AluReq, 0);
        check("rst_alu_ab", {bus.AluA, bus.AluB}, 0);
        check("rst_aluctl", bus.AluControl, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // 6*7: three adds in cycles 1-3, result in cycle 4
        start_op(32'd6, 32'd7, 1);
        wait_result(0, 4, 3, 1, 1, "t1");

        // multiplier zero skips straight to done
        start_op(32'd5, 32'd0, 1);
        wait_result(0, 1, 0, 0, 1, "t2");

        // all-ones squared wraps to 1 after 32 iterations
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        wait_result(0, 33, 32, 1, 1, "t3");

        // no early exit: OpB=1 still runs the full 32 iterations
        @(negedge clk);
        bus0.InValid = 1'b1; bus0.OpA = 32'hDEAD_BEEF; bus0.OpB = 32'd1;
        @(posedge clk);
        done0 = 1'b0; lat0 = 0; nreq0 = 0;
        for (int c = 1; c <= 100 && !done0; c++) begin
            @(negedge clk);
            bus0.InValid = 1'b0;
            if (bus0.OutValid) begin
                lat0  = c;
                done0 = 1'b1;
            end else if (bus0.AluReq) begin
                nreq0++;
            end
        end
        check("t3b_latency", lat0, 33);
        check("t3b_product", bus0.Product, 32'hDEAD_BEEF);
        check("t3b_req_cycles", nreq0, 1);
        bus0.OutReady = 1'b1;
        @(negedge clk);
        bus0.OutReady = 1'b0;
        check("t3b_post_inready", bus0.InReady, 1);

        // 3 grant stalls on the first request: N=4, S=3 -> cycle 8; 5 request cycles in total
        bus.AluGnt = 1'b0;
        start_op(32'h1234_5678, 32'd9, 1);
        wait_result(3, 8, 5, 1, 1, "t4");

        // result held under backpressure while a new op is offered and ignored
        start_op(32'd3, 32'd4, 1);
        wait_result(0, 4, 1, 3, 0, "t5a");
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("t5_hold_outvalid", bus.OutValid, 1);
            check("t5_hold_product", bus.Product, 32'd12);
            check("t5_hold_inready", bus.InReady, 0);
            bus.InValid = (k == 1);
            bus.OpA = 32'd100;
            bus.OpB = 32'd100;
        end
        bus.InValid = 1'b0;
        handshake("t5a");
        check("t5_not_taken", bus.Busy, 0);
        start_op(32'd100, 32'd100, 1);
        wait_result(0, 8, 3, 3, 1, "t5b");

        // flush in cycle 2 of 0xFF*0xFF
        start_op(32'hFF, 32'hFF, 0);
        @(negedge clk);
        bus.InValid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("t6_flush_busy", bus.Busy, 0);
        check("t6_flush_alureq", bus.AluReq, 0);
        check("t6_flush_inready", bus.InReady, 1);
        ov_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.OutValid) ov_cnt++;
        end
        check("t6_outvalid_never", ov_cnt, 0);

        // flush together with InValid in idle: nothing accepted
        bus.InValid = 1'b1; bus.OpA = 32'd3; bus.OpB = 32'd3;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bus.InValid = 1'b0;
        check("t6_flush_vs_invalid", bus.Busy, 0);

        // asynchronous reset in the middle of a run
        start_op(32'hFF, 32'hFF, 0);
        @(negedge clk);
        bus.InValid = 1'b0;
        @(negedge clk);
        check("t6_midrun_busy", bus.Busy, 1);
        #1 reset_n = 1'b0;
        #1;
        check("t6_arst_busy", bus.Busy, 0);
        check("t6_arst_inready", bus.InReady, 1);
        check("t6_arst_outvalid", bus.OutValid, 0);
        check("t6_arst_product", bus.Product, 0);
        check("t6_arst_alureq", bus.AluReq, 0);
        check("t6_arst_alu_ab", {bus.AluA, bus.AluB}, 0);
        check("t6_arst_aluctl", bus.AluControl, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
